// File: rtl/atmega_pcint_pkg.sv
// Shared definitions for the ATMEGA pin-change interrupt controller: default
// IO addresses, control/flag bit positions and the debounce counter width.
package atmega_pcint_pkg;

  localparam int unsigned PCICR_ADDR_DEF = 32'h68;
  localparam int unsigned PCIFR_ADDR_DEF = 32'h3B;
  localparam int unsigned PCMSK_ADDR_DEF = 32'h6B;
  localparam int unsigned PCHG_ADDR_DEF  = 32'h6C;

  localparam int unsigned PCIE_BIT = 0;
  localparam int unsigned PCIF_BIT = 0;

  typedef enum logic [2:0] {
    REG_NONE,
    REG_PCICR,
    REG_PCIFR,
    REG_PCMSK,
    REG_PCHG
  } reg_sel_e;

  // Width able to hold the value DEBOUNCE_CYCLES itself.
  function automatic int unsigned debounce_cnt_w(input int unsigned cycles);
    return (cycles < 2) ? 1 : $clog2(cycles + 1);
  endfunction

endpackage

// File: rtl/atmega_pcint_debounce.sv
// One-pin debouncer: a level is accepted only after it has differed from the
// current stable value for DEBOUNCE_CYCLES consecutive rising edges.
module atmega_pcint_debounce
  import atmega_pcint_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic init,
  input  logic pin,
  output logic stable
);

  localparam int unsigned CNT_W = debounce_cnt_w(DEBOUNCE_CYCLES);

  logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc;
  logic             stable_q, stable_d;

  assign cnt_inc = cnt_q + 1'b1;

  // NOTE: every signal written here gets a default first so no latch is inferred.
  always_comb begin
    cnt_d    = cnt_q;
    stable_d = stable_q;
    if (!init) begin
      stable_d = pin;
      cnt_d    = '0;
    end else if (pin == stable_q) begin
      cnt_d = '0;
    end else if (cnt_inc == CNT_W'(DEBOUNCE_CYCLES)) begin
      stable_d = pin;
      cnt_d    = '0;
    end else begin
      cnt_d = cnt_inc;
    end
  end

  // NOTE: state registers use non-blocking assignments so all flops update together.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q    <= '0;
      stable_q <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      stable_q <= stable_d;
    end
  end

  // The next stable value lets the parent flag the change on the accepting edge.
  assign stable = stable_d;

endmodule

// File: rtl/atmega_pcint.sv
// Pin-change interrupt controller for one 8-bit PIO port.
// Optional per-pin debounce is compiled in with ATMEGA_PCINT_DEBOUNCE_EN.
module atmega_pcint
  import atmega_pcint_pkg::*;
#(
  parameter int unsigned                BUS_ADDR_IO_LEN = 16,
  parameter logic [BUS_ADDR_IO_LEN-1:0] PCICR_ADDR      = BUS_ADDR_IO_LEN'(PCICR_ADDR_DEF),
  parameter logic [BUS_ADDR_IO_LEN-1:0] PCIFR_ADDR      = BUS_ADDR_IO_LEN'(PCIFR_ADDR_DEF),
  parameter logic [BUS_ADDR_IO_LEN-1:0] PCMSK_ADDR      = BUS_ADDR_IO_LEN'(PCMSK_ADDR_DEF),
  parameter logic [BUS_ADDR_IO_LEN-1:0] PCHG_ADDR       = BUS_ADDR_IO_LEN'(PCHG_ADDR_DEF),
  parameter int unsigned                DEBOUNCE_CYCLES = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [BUS_ADDR_IO_LEN-1:0] addr,
  input  logic                       wr,
  input  logic                       rd,
  input  logic [7:0]                 bus_in,
  output logic [7:0]                 bus_out,
  input  logic [7:0]                 pin_in,
  output logic                       int_o,
  input  logic                       int_ack
);

  logic       init_q;
  logic [7:0] stable_q, stable_nxt;
  logic       pcie_q, pcie_d;
  logic       pcif_q, pcif_d;
  logic [7:0] pcmsk_q, pcmsk_d;
  logic [7:0] pchg_q, pchg_d;
  logic [7:0] edge_v;
  logic       flag_clr;
  reg_sel_e   sel;

`ifdef ATMEGA_PCINT_DEBOUNCE_EN
  for (genvar i = 0; i < 8; i++) begin : g_debounce
    atmega_pcint_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_debounce (
      .clk   (clk),
      .rst   (rst),
      .init  (init_q),
      .pin   (pin_in[i]),
      .stable(stable_nxt[i])
    );
  end
`else
  assign stable_nxt = pin_in;
`endif

  always_comb begin
    sel = REG_NONE;
    if      (addr == PCICR_ADDR) sel = REG_PCICR;
    else if (addr == PCIFR_ADDR) sel = REG_PCIFR;
    else if (addr == PCMSK_ADDR) sel = REG_PCMSK;
    else if (addr == PCHG_ADDR)  sel = REG_PCHG;
  end

  // The first cycle after reset only primes stable_q, so a high pin is not an edge.
  assign edge_v   = init_q ? ((stable_nxt ^ stable_q) & pcmsk_q) : 8'h00;
  assign flag_clr = pcif_q & (int_ack | (wr & (sel == REG_PCIFR) & bus_in[PCIF_BIT]));

  always_comb begin
    pcie_d  = pcie_q;
    pcmsk_d = pcmsk_q;
    pcif_d  = pcif_q;
    pchg_d  = pchg_q;
    if (wr && sel == REG_PCICR) pcie_d  = bus_in[PCIE_BIT];
    if (wr && sel == REG_PCMSK) pcmsk_d = bus_in;
    // A new edge beats a simultaneous clear; PCHG then holds only the new edge.
    if (|edge_v) begin
      pcif_d = 1'b1;
      pchg_d = flag_clr ? edge_v : (pchg_q | edge_v);
    end else if (flag_clr) begin
      pcif_d = 1'b0;
      pchg_d = 8'h00;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      init_q   <= 1'b0;
      stable_q <= 8'h00;
      pcie_q   <= 1'b0;
      pcif_q   <= 1'b0;
      pcmsk_q  <= 8'h00;
      pchg_q   <= 8'h00;
    end else begin
      init_q   <= 1'b1;
      stable_q <= stable_nxt;
      pcie_q   <= pcie_d;
      pcif_q   <= pcif_d;
      pcmsk_q  <= pcmsk_d;
      pchg_q   <= pchg_d;
    end
  end

  assign int_o = pcif_q & pcie_q;

  always_comb begin
    bus_out = 8'h00;
    if (rd && !rst) begin
      case (sel)
        REG_PCICR: bus_out = {7'b0, pcie_q};
        REG_PCIFR: bus_out = {7'b0, pcif_q};
        REG_PCMSK: bus_out = pcmsk_q;
        REG_PCHG:  bus_out = pchg_q;
        default:   bus_out = 8'h00;
      endcase
    end
  end

endmodule

// File: tb/tb_atmega_pcint.sv
// Self-checking bench for atmega_pcint; expected values are queued when the
// stimulus is applied and compared when the DUT output is sampled.
module tb_atmega_pcint;

  localparam logic [15:0] A_PCICR = 16'h0068;
  localparam logic [15:0] A_PCIFR = 16'h003B;
  localparam logic [15:0] A_PCMSK = 16'h006B;
  localparam logic [15:0] A_PCHG  = 16'h006C;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] addr;
  logic        wr;
  logic        rd;
  logic [7:0]  bus_in;
  logic [7:0]  bus_out;
  logic [7:0]  pin_in;
  logic        int_o;
  logic        int_ack;

  typedef struct {
    string      tag;
    logic [7:0] exp;
  } sb_item_t;

  sb_item_t sb[$];
  int       checks   = 0;
  int       failures = 0;

  atmega_pcint dut (
    .clk    (clk),
    .rst    (rst),
    .addr   (addr),
    .wr     (wr),
    .rd     (rd),
    .bus_in (bus_in),
    .bus_out(bus_out),
    .pin_in (pin_in),
    .int_o  (int_o),
    .int_ack(int_ack)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got=%02h expected=%02h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic sb_pop(input logic [7:0] got);
    sb_item_t e;
    if (sb.size() == 0) begin
      checks++;
      failures++;
      $display("FAIL scoreboard_empty: got=%02h expected=none", got);
    end else begin
      e = sb.pop_front();
      check(e.tag, got, e.exp);
    end
  endtask

  task automatic write_reg(input logic [15:0] a, input logic [7:0] d);
    addr   = a;
    bus_in = d;
    wr     = 1'b1;
    tick();
    wr     = 1'b0;
  endtask

  task automatic expect_reg(input string tag, input logic [15:0] a, input logic [7:0] exp);
    sb.push_back('{tag, exp});
    addr = a;
    rd   = 1'b1;
    @(negedge clk);
    sb_pop(bus_out);
    rd = 1'b0;
    tick();
  endtask

  task automatic expect_int(input string tag, input logic exp);
    sb.push_back('{tag, {7'b0, exp}});
    @(negedge clk);
    sb_pop({7'b0, int_o});
    tick();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got=timeout expected=finish");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; addr = '0; wr = 1'b0; rd = 1'b0; bus_in = '0;
    pin_in = 8'hFF; int_ack = 1'b0;
    repeat (3) tick();
    expect_reg("rst_bus_out", A_PCHG, 8'h00);
    expect_int("rst_int", 1'b0);

    rst = 1'b0;
    for (int i = 0; i < 20; i++) expect_int("quiet_int", 1'b0);
    expect_reg("quiet_pcif", A_PCIFR, 8'h00);

    write_reg(A_PCMSK, 8'h05);
    write_reg(A_PCICR, 8'h01);
    expect_reg("pcmsk_rd", A_PCMSK, 8'h05);
    expect_reg("pcicr_rd", A_PCICR, 8'h01);

`ifndef ATMEGA_PCINT_DEBOUNCE_EN
    pin_in = 8'hFB;
    expect_int("pin2_pre_edge", 1'b0);
    expect_int("pin2_int_rise", 1'b1);
    expect_reg("pin2_pcif", A_PCIFR, 8'h01);
    expect_reg("pin2_pchg", A_PCHG, 8'h04);

    write_reg(A_PCIFR, 8'h00);
    expect_reg("w0_pcifr_noop", A_PCIFR, 8'h01);
    write_reg(A_PCHG, 8'hFF);
    expect_reg("pchg_read_only", A_PCHG, 8'h04);
    write_reg(A_PCIFR, 8'h01);
    expect_reg("w1c_pcif", A_PCIFR, 8'h00);
    expect_reg("w1c_pchg", A_PCHG, 8'h00);
    expect_int("w1c_int", 1'b0);

    pin_in = 8'hF9;
    repeat (5) tick();
    expect_reg("masked_pin1", A_PCIFR, 8'h00);

    pin_in = 8'hF8;
    tick();
    expect_reg("pin0_pchg", A_PCHG, 8'h01);
    expect_int("pin0_int", 1'b1);
    int_ack = 1'b1;
    expect_int("ack_edge_int", 1'b1);
    int_ack = 1'b0;
    expect_int("ack_int_fall", 1'b0);
    expect_reg("ack_pchg", A_PCHG, 8'h00);

    int_ack = 1'b1;
    tick();
    int_ack = 1'b0;
    expect_reg("ack_idle", A_PCIFR, 8'h00);

    pin_in = 8'hFC;
    tick();
    expect_reg("pre_race_pchg", A_PCHG, 8'h04);
    pin_in = 8'hFD;
    write_reg(A_PCIFR, 8'h01);
    expect_reg("race_pcif", A_PCIFR, 8'h01);
    expect_reg("race_pchg", A_PCHG, 8'h01);

    write_reg(A_PCMSK, 8'h00);
    pin_in = 8'hF8;
    tick();
    expect_reg("mask_keeps_pchg", A_PCHG, 8'h01);
    expect_reg("mask_zero_rd", A_PCMSK, 8'h00);
    expect_reg("bad_addr", 16'h0010, 8'h00);

    rst = 1'b1;
    tick();
    rst = 1'b0;
    expect_reg("mid_rst_pcif", A_PCIFR, 8'h00);
    expect_reg("mid_rst_pchg", A_PCHG, 8'h00);
    expect_reg("mid_rst_pcicr", A_PCICR, 8'h00);
    expect_int("mid_rst_int", 1'b0);
`else
    pin_in = 8'hFE;
    repeat (10) tick();
    pin_in = 8'hFF;
    repeat (30) tick();
    expect_reg("glitch_dropped", A_PCIFR, 8'h00);

    pin_in = 8'hFE;
    repeat (15) tick();
    expect_reg("db_edge15", A_PCIFR, 8'h00);
    expect_reg("db_edge16", A_PCIFR, 8'h01);
    expect_reg("db_pchg", A_PCHG, 8'h01);
    int_ack = 1'b1;
    tick();
    int_ack = 1'b0;
    expect_int("db_ack_int", 1'b0);

    pin_in = 8'hFF;
    repeat (8) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    expect_reg("db_rst_pcmsk", A_PCMSK, 8'h00);
    write_reg(A_PCMSK, 8'h01);
    write_reg(A_PCICR, 8'h01);
    repeat (20) tick();
    expect_reg("db_rst_no_flag", A_PCIFR, 8'h00);
    expect_int("db_rst_int", 1'b0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
